regbank_2r1w: RTL and testbench

- Parametrised successor register bank for the CoreBassier datapath: one synchronous write port, two registered read ports (rs1/rs2 style).
- Adds write-to-read bypass, an optional hardwired-zero register 0, and a hardware clear sequencer.
- The clear sequencer zeroes every entry after reset, or on request, and reports progress through a busy flag.
- Sits between decode (read addresses) and writeback (write port) of the core.

---
 rtl/regbank_2r1w.sv | 127 ++++++++++++
 tb/tb_regbank_2r1w.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_2r1w.sv
// regbank_2r1w: parametrised register bank with one synchronous write port,
// two registered read ports (A/B), write-first bypass, optional hardwired
// zero register and a hardware clear sweep that zeroes every entry after
// reset or on request.
module regbank_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Sweep ends on the edge that writes the last entry; detected by compare,
  // never by relying on the pointer wrapping.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [DATA_WIDTH-1:0] r_q_a;
  logic [DATA_WIDTH-1:0] r_q_b;
  logic [DATA_WIDTH-1:0] r_ram [DEPTH];

  logic                  w_zero_wa;
  logic                  w_wr_eff;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [DATA_WIDTH-1:0] w_rd_a;
  logic [DATA_WIDTH-1:0] w_rd_b;

  // A write is effective only in IDLE, without a clear request, and not
  // aimed at the hardwired zero register.
  assign w_zero_wa = (ZERO_REG != 0) && (write_addr == '0);
  assign w_wr_eff  = (r_state == ST_IDLE) && we && !clear && !w_zero_wa;

  // Single array write port, shared between the sweep and normal writes.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = write_addr;
    w_ram_wdata = data;
    if (r_state == ST_CLEAR) begin
      w_ram_we    = 1'b1;
      w_ram_addr  = r_ptr;
      w_ram_wdata = '0;
    end else if (w_wr_eff) begin
      w_ram_we = 1'b1;
    end
  end

  // Next read data for port A: zero register, then bypass, then array.
  always_comb begin
    w_rd_a = r_ram[read_addr_a];
    if ((ZERO_REG != 0) && (read_addr_a == '0)) begin
      w_rd_a = '0;
    end else if (w_wr_eff && (write_addr == read_addr_a)) begin
      w_rd_a = data;
    end
  end

  // Next read data for port B: same rules as port A, independent address.
  always_comb begin
    w_rd_b = r_ram[read_addr_b];
    if ((ZERO_REG != 0) && (read_addr_b == '0)) begin
      w_rd_b = '0;
    end else if (w_wr_eff && (write_addr == read_addr_b)) begin
      w_rd_b = data;
    end
  end

  // Storage array; contents are not reset, the sweep zeroes them.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_ram_addr] <= w_ram_wdata;
    end
  end

  // Control FSM with registered read outputs and sweep pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
      r_q_a   <= '0;
      r_q_b   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_q_a <= '0;
          r_q_b <= '0;
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == LAST_ADDR) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_q_a <= w_rd_a;
          r_q_b <= w_rd_b;
          if (clear) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
          end
        end
      endcase
    end
  end

  assign q_a  = r_q_a;
  assign q_b  = r_q_b;
  assign busy = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_regbank_2r1w.sv
// Bench for regbank_2r1w: two instances (ZERO_REG = 1 and 0) driven in
// parallel, checked every cycle against a behavioural model, plus directed
// literal expectations and a randomized phase.
module tb_regbank_2r1w;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] data = '0;
  logic [AW-1:0] read_addr_a = '0;
  logic [AW-1:0] read_addr_b = '0;
  logic          clear = 1'b0;

  logic [DW-1:0] qa1, qb1, qa0, qb0;
  logic          busy1, busy0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  regbank_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .we(we), .write_addr(write_addr), .data(data),
    .read_addr_a(read_addr_a), .read_addr_b(read_addr_b), .clear(clear),
    .q_a(qa1), .q_b(qb1), .busy(busy1)
  );

  regbank_2r1w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .we(we), .write_addr(write_addr), .data(data),
    .read_addr_a(read_addr_a), .read_addr_b(read_addr_b), .clear(clear),
    .q_a(qa0), .q_b(qb0), .busy(busy0)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index 0 models ZERO_REG = 0, index 1 models ZERO_REG = 1.
  // A sweep is modelled as "outputs 0, writes ignored for DEPTH edges, then
  // every entry is 0"; the per-entry progress is not observable.
  logic [DW-1:0] m_mem [2][DEPTH];
  logic [DW-1:0] m_qa [2];
  logic [DW-1:0] m_qb [2];
  int            m_left = 0;

  function automatic bit m_eff(input int z);
    return we && !clear && !((z == 1) && (write_addr == '0));
  endfunction

  function automatic logic [DW-1:0] m_pick(input int z, input logic [AW-1:0] ra,
                                           input logic [DW-1:0] stored);
    if ((z == 1) && (ra == '0)) return '0;
    if (m_eff(z) && (write_addr == ra)) return data;
    return stored;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= DEPTH;
      for (int z = 0; z < 2; z++) begin
        m_qa[z] <= '0;
        m_qb[z] <= '0;
        for (int i = 0; i < DEPTH; i++) m_mem[z][i] <= '0;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      for (int z = 0; z < 2; z++) begin
        m_qa[z] <= '0;
        m_qb[z] <= '0;
      end
    end else begin
      for (int z = 0; z < 2; z++) begin
        m_qa[z] <= m_pick(z, read_addr_a, m_mem[z][read_addr_a]);
        m_qb[z] <= m_pick(z, read_addr_b, m_mem[z][read_addr_b]);
        if (clear) begin
          for (int i = 0; i < DEPTH; i++) m_mem[z][i] <= '0;
        end else if (m_eff(z)) begin
          m_mem[z][write_addr] <= data;
        end
      end
      if (clear) m_left <= DEPTH;
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("z1.q_a", qa1, m_qa[1]);
      chk("z1.q_b", qb1, m_qb[1]);
      chk("z1.busy", {31'b0, busy1}, {31'b0, (m_left != 0)});
      chk("z0.q_a", qa0, m_qa[0]);
      chk("z0.q_b", qb0, m_qb[0]);
      chk("z0.busy", {31'b0, busy0}, {31'b0, (m_left != 0)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_in();
    we = 1'b0; clear = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; write_addr = a; data = d; clear = 1'b0;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
    we = 1'b0; clear = 1'b0; read_addr_a = a; read_addr_b = b;
    cyc();
  endtask

  // Counts edges until busy falls, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy1 && n < 200) begin
      cyc();
      n++;
    end
  endtask

  int n;

  initial begin
    #1 rst_n = 1'b0;
    cyc();
    chk_en = 1'b1;
    chk("reset q_a", qa1, '0);
    chk("reset busy", {31'b0, busy1}, 32'd1);
    rst_n = 1'b1;

    // Reset release: sweep is exactly DEPTH edges; everything reads 0.
    count_busy(n);
    chk("reset sweep length", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i), AW'(DEPTH - 1 - i));
      chk("post-reset zero z0", qa0, '0);
    end

    // Plain write then read.
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd6);
    chk("read addr5", qa1, 32'hDEADBEEF);
    chk("read addr6", qb1, 32'h0);

    // Write-first bypass on both ports.
    wr(5'd7, 32'hAAAA0000);
    we = 1'b1; write_addr = 5'd7; data = 32'h12345678;
    read_addr_a = 5'd7; read_addr_b = 5'd7;
    cyc();
    idle_in();
    chk("bypass q_a", qa1, 32'h12345678);
    chk("bypass q_b", qb1, 32'h12345678);
    rd(5'd7, 5'd5);
    chk("after bypass", qa1, 32'h12345678);

    // Zero register behaviour on both instances.
    we = 1'b1; write_addr = 5'd0; data = 32'hFFFFFFFF; read_addr_b = 5'd0;
    cyc();
    idle_in();
    chk("zreg bypass z1", qb1, 32'h0);
    chk("zreg bypass z0", qb0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    chk("zreg later z1", qa1, 32'h0);
    chk("zreg later z0", qa0, 32'hFFFFFFFF);

    // Fill, then clear together with a dropped write.
    for (int i = 1; i < DEPTH; i++) wr(AW'(i), DW'(i));
    clear = 1'b1; we = 1'b1; write_addr = 5'd3; data = 32'h99;
    read_addr_a = 5'd3; read_addr_b = 5'd31;
    cyc();
    idle_in();
    chk("clear-edge read a", qa1, 32'd3);
    chk("clear-edge read b", qb1, 32'd31);
    clear = 1'b1;  // ignored while sweeping
    cyc();
    clear = 1'b0;
    count_busy(n);
    chk("clear sweep length", n, DEPTH - 1);
    rd(5'd3, 5'd31);
    chk("cleared addr3", qa1, 32'h0);
    chk("cleared addr31", qb1, 32'h0);

    // Reset mid-sweep (ptr = 17) with writes attempted during sweep.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    we = 1'b1; write_addr = 5'd9; data = 32'h55;
    repeat (17) cyc();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    count_busy(n);
    idle_in();
    chk("mid-sweep reset length", n, DEPTH);
    rd(5'd9, 5'd9);
    chk("sweep write ignored", qa1, 32'h0);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      we          = $urandom_range(0, 1) == 1;
      write_addr  = AW'($urandom);
      data        = $urandom;
      read_addr_a = ($urandom_range(0, 3) == 0) ? write_addr : AW'($urandom);
      read_addr_b = ($urandom_range(0, 3) == 0) ? write_addr : AW'($urandom);
      clear       = $urandom_range(0, 99) == 0;
      rst_n       = $urandom_range(0, 599) != 0;
      cyc();
    end
    rst_n = 1'b1;
    idle_in();
    count_busy(n);
    chk("final idle", {31'b0, busy1}, 32'd0);
    cyc();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
